branch_predictor: RTL and testbench

- Fetch-side counterpart to the branch comparator.
- Predicts at fetch whether a control-transfer instruction will be taken, and predicts its target.
- Consumes the comparator's resolved outcome (branch_taken, Jump) from execute to train its tables.
- Raises a registered redirect/flush request when a resolved outcome disagrees with the prediction carried down the pipe.

---
 rtl/branch_predictor.sv | 88 ++++++++
 tb/tb_branch_predictor.sv | 116 +++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: BHT/BTB fetch predictor trained by resolved outcomes; registered redirect on mispredict.
// Optional BP_STATS_EN adds resolve/mispredict counters.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int IDX_W = 6,
  parameter int TAG_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] f_pc,
  output logic        f_pred_taken,
  output logic [31:0] f_pred_target,
  input  logic        r_valid,
  input  logic [31:0] r_pc,
  input  logic        r_jump,
  input  logic        r_taken,
  input  logic [31:0] r_target,
  input  logic        r_pred_taken,
  input  logic [31:0] r_pred_target,
  output logic        redirect,
  output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_resolved,
  output logic [31:0] stat_mispred
`endif
);
  logic [ENTRIES-1:0] r_val;
  logic [1:0]         r_cnt [ENTRIES];
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [31:0]        r_tgt [ENTRIES];
  logic [IDX_W-1:0]   w_fidx, w_ridx;
  logic [TAG_W-1:0]   w_ftag, w_rtag;
  logic [1:0]         w_cnt, w_cnt_nxt;
  logic               w_fhit, w_rhit, w_mis, w_upd, w_we_cnt, w_we_tt, w_unused;
  assign w_fidx = f_pc[IDX_W+1:2];
  assign w_ftag = f_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_ridx = r_pc[IDX_W+1:2];
  assign w_rtag = r_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_unused = ^{f_pc[31:IDX_W+TAG_W+2], f_pc[1:0]};
  assign w_fhit = r_val[w_fidx] & (r_tag[w_fidx] == w_ftag);
  assign f_pred_taken = w_fhit & r_cnt[w_fidx][1];
  assign f_pred_target = f_pred_taken ? r_tgt[w_fidx] : '0;
  assign w_rhit = r_val[w_ridx] & (r_tag[w_ridx] == w_rtag);
  assign w_cnt = r_cnt[w_ridx];
  assign w_mis = (r_pred_taken != r_taken) | (r_taken & r_pred_taken & (r_pred_target != r_target));
  assign w_upd = r_valid & ~rst;
  // not-taken misses never allocate; taken resolves always (re)write tag and target
  assign w_we_cnt = w_upd & (w_rhit | r_taken);
  assign w_we_tt = w_upd & r_taken;
  always_comb
    w_cnt_nxt = r_jump ? 2'b11 :
                !w_rhit ? 2'b10 :
                r_taken ? ((w_cnt == 2'b11) ? w_cnt : w_cnt + 2'b01) :
                ((w_cnt == 2'b00) ? w_cnt : w_cnt - 2'b01);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_val <= '0;
      for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= 2'b01;
      redirect <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect <= r_valid & w_mis;
      if (r_valid & w_mis) redirect_pc <= r_taken ? r_target : r_pc + 32'd4;
      if (w_we_cnt) begin
        r_val[w_ridx] <= 1'b1;
        r_cnt[w_ridx] <= w_cnt_nxt;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_we_tt) begin
      r_tag[w_ridx] <= w_rtag;
      r_tgt[w_ridx] <= r_target;
    end
  end
`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_resolved <= '0;
      stat_mispred <= '0;
    end else if (r_valid) begin
      stat_resolved <= stat_resolved + 32'd1;
      if (w_mis) stat_mispred <= stat_mispred + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vectors with a queued scoreboard for lookup and redirect checks.
module tb_branch_predictor;
  logic        clk, rst, f_pred_taken, r_valid, r_jump, r_taken, r_pred_taken, redirect;
  logic [31:0] f_pc, f_pred_target, r_pc, r_target, r_pred_target, redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_resolved, stat_mispred;
`endif
  typedef struct {
    bit          chk;
    bit          t;
    logic [31:0] v;
  } exp_t;
  exp_t lk_q[$];
  exp_t rd_q[$];
  int n_vec = 0;
  int n_mis = 0;

  branch_predictor dut (
    .clk(clk), .rst(rst), .f_pc(f_pc), .f_pred_taken(f_pred_taken), .f_pred_target(f_pred_target),
    .r_valid(r_valid), .r_pc(r_pc), .r_jump(r_jump), .r_taken(r_taken), .r_target(r_target),
    .r_pred_taken(r_pred_taken), .r_pred_target(r_pred_target), .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef BP_STATS_EN
    , .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // lookup is checked before the edge, so it sees pre-update table contents
  always @(negedge clk) begin
    if (lk_q.size() > 0) begin
      exp_t e;
      e = lk_q.pop_front();
      if (e.chk) begin
        chk("f_pred_taken", {31'd0, f_pred_taken}, {31'd0, e.t});
        chk("f_pred_target", f_pred_target, e.v);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rd_q.size() > 0) begin
      exp_t e;
      e = rd_q.pop_front();
      chk("redirect", {31'd0, redirect}, {31'd0, e.t});
      chk("redirect_pc", redirect_pc, e.v);
    end
  end

  task automatic step(input bit rs, input logic [31:0] fpc, input bit rv, input logic [31:0] rpc,
                      input bit rj, input bit rt, input logic [31:0] rtgt, input bit rpt,
                      input logic [31:0] rptgt, input bit el, input bit ept, input logic [31:0] eptgt,
                      input bit er, input logic [31:0] erpc);
    exp_t a, b;
    @(posedge clk);
    #2;
    rst = rs; f_pc = fpc; r_valid = rv; r_pc = rpc; r_jump = rj; r_taken = rt;
    r_target = rtgt; r_pred_taken = rpt; r_pred_target = rptgt;
    a.chk = el; a.t = ept; a.v = eptgt;
    b.chk = 1; b.t = er; b.v = erpc;
    lk_q.push_back(a);
    rd_q.push_back(b);
  endtask

  initial begin
    rst = 1; f_pc = 0; r_valid = 0; r_pc = 0; r_jump = 0; r_taken = 0;
    r_target = 0; r_pred_taken = 0; r_pred_target = 0;
    //   rst fpc        rv rpc          j t rtgt     pt rptgt     el et etgt     er erpc
    step(1, 32'h100, 0, 32'h0,       0,0,32'h0,    0,32'h0,     0,0,32'h0,    0,32'h0);
    step(0, 32'h100, 0, 32'h0,       0,0,32'h0,    0,32'h0,     1,0,32'h0,    0,32'h0);
    step(0, 32'h100, 1, 32'h100,     0,1,32'h40,   0,32'h0,     1,0,32'h0,    1,32'h40);
    step(0, 32'h100, 0, 32'h0,       0,0,32'h0,    0,32'h0,     1,1,32'h40,   0,32'h40);
    step(0, 32'h100, 1, 32'h100,     0,0,32'h40,   1,32'h40,    1,1,32'h40,   1,32'h104);
    step(0, 32'h100, 1, 32'h100,     0,0,32'h40,   0,32'h0,     1,0,32'h0,    0,32'h104);
    step(0, 32'h100, 1, 32'h100,     0,0,32'h40,   0,32'h0,     1,0,32'h0,    0,32'h104);
    step(0, 32'h100, 1, 32'h100,     0,1,32'h40,   0,32'h0,     1,0,32'h0,    1,32'h40);
    step(0, 32'h100, 0, 32'h0,       0,0,32'h0,    0,32'h0,     1,0,32'h0,    0,32'h40);
    step(0, 32'h200, 1, 32'h200,     1,1,32'h800,  0,32'h0,     1,0,32'h0,    1,32'h800);
    step(0, 32'h200, 0, 32'h0,       0,0,32'h0,    0,32'h0,     1,1,32'h800,  0,32'h800);
    step(0, 32'h200, 1, 32'h200,     1,1,32'h800,  1,32'h7FC,   1,1,32'h800,  1,32'h800);
    step(0, 32'h200, 1, 32'h200,     0,1,32'h900,  1,32'h800,   1,1,32'h800,  1,32'h900);
    step(0, 32'h200, 0, 32'h0,       0,0,32'h0,    0,32'h0,     1,1,32'h900,  0,32'h900);
    step(0, 32'h200, 1, 32'h200,     0,0,32'h900,  1,32'h900,   1,1,32'h900,  1,32'h204);
    step(0, 32'h200, 0, 32'h0,       0,0,32'h0,    0,32'h0,     1,1,32'h900,  0,32'h204);
    step(0, 32'h300, 1, 32'h300,     0,1,32'h1000, 0,32'h0,     1,0,32'h0,    1,32'h1000);
    step(0, 32'h300, 0, 32'h0,       0,0,32'h0,    0,32'h0,     1,1,32'h1000, 0,32'h1000);
    step(0, 32'h400, 0, 32'h0,       0,0,32'h0,    0,32'h0,     1,0,32'h0,    0,32'h1000);
    step(0, 32'h300, 1, 32'h400,     0,0,32'h0,    0,32'h0,     1,1,32'h1000, 0,32'h1000);
    step(0, 32'h300, 0, 32'h0,       0,0,32'h0,    0,32'h0,     1,1,32'h1000, 0,32'h1000);
    step(1, 32'h300, 1, 32'h104,     0,1,32'h50,   0,32'h0,     1,1,32'h1000, 0,32'h0);
    step(0, 32'h104, 0, 32'h0,       0,0,32'h0,    0,32'h0,     1,0,32'h0,    0,32'h0);
    step(0, 32'h300, 1, 32'h104,     0,1,32'h50,   0,32'h0,     1,0,32'h0,    1,32'h50);
    step(0, 32'h104, 1, 32'hFFFFFFFC,0,0,32'h0,    1,32'h1234,  1,1,32'h50,   1,32'h0);
    step(0, 32'h104, 0, 32'h0,       0,0,32'h0,    0,32'h0,     1,1,32'h50,   0,32'h0);
    repeat (3) @(posedge clk);
    #3;
    chk("lookup_queue_drained", lk_q.size(), 0);
    chk("redirect_queue_drained", rd_q.size(), 0);
`ifdef BP_STATS_EN
    chk("stat_resolved", stat_resolved, 32'd13);
    chk("stat_mispred", stat_mispred, 32'd10);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
